// File: rtl/data_memory_controller.sv
// rtl/data_memory_controller.sv - two-port sized load/store sequencer for the 64-byte data memory
// Optional feature macro: DMC_ROUND_ROBIN_EN (round-robin arbitration; fixed port-0 priority when undefined)
module data_memory_controller #(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [1:0]        p0_size,
  input  logic              p0_unsigned,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [63:0]       p0_wdata,
  output logic              p0_done,
  output logic              p0_err,
  output logic [63:0]       p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [1:0]        p1_size,
  input  logic              p1_unsigned,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [63:0]       p1_wdata,
  output logic              p1_done,
  output logic              p1_err,
  output logic [63:0]       p1_rdata,
  output logic [ADDR_W-1:0] Memory_Address,
  output logic [63:0]       Write_Data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [63:0]       Read_Data
);

  typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, RESP} state_t;

  state_t state, state_next;

  // Fields of the transaction in flight, latched at grant
  logic              cur_port;
  logic              cur_we;
  logic              cur_uns;
  logic [1:0]        cur_size;
  logic [ADDR_W-1:0] cur_addr;
  logic [63:0]       cur_wdata;
  logic              cur_err;
  logic [63:0]       line;

  logic              grant_valid;
  logic              grant_port;
  logic [3:0]        nbytes;
  logic              misaligned;
  logic [ADDR_W:0]   end_addr;
  logic              chk_err;
  logic [63:0]       merged;
  logic [63:0]       shifted;
  logic [63:0]       extended;
  logic [63:0]       load_data;

`ifdef DMC_ROUND_ROBIN_EN
  // Port that wins the next simultaneous request: the one not granted last
  logic prefer;

  // Arbitration: alternate between ports when both are requesting
  always_comb begin
    grant_valid = p0_req | p1_req;
    grant_port  = 1'b0;
    if (p0_req && p1_req) grant_port = prefer;
    else if (p1_req)      grant_port = 1'b1;
  end

  // Round-robin pointer moves at every grant
  always_ff @(posedge clock) begin
    if (reset)                          prefer <= 1'b0;
    else if (state == IDLE && grant_valid) prefer <= ~grant_port;
  end
`else
  // Arbitration: port 0 always wins, port 1 only when port 0 is quiet
  always_comb begin
    grant_valid = p0_req | p1_req;
    grant_port  = ~p0_req;
  end
`endif

  // Alignment and range check on the latched request; the sum is one bit wider so top-of-space addresses cannot wrap
  always_comb begin
    nbytes     = 4'd1 << cur_size;
    misaligned = (cur_addr[2:0] & (nbytes[2:0] - 3'd1)) != 3'd0;
    end_addr   = {1'b0, cur_addr} + {{(ADDR_W-3){1'b0}}, nbytes};
    chk_err    = misaligned || (end_addr > (ADDR_W+1)'(MEM_BYTES));
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and memory strobes, decoded from the state only
  always_comb begin
    state_next = state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    case (state)
      IDLE:  if (grant_valid) state_next = CHECK;
      CHECK: begin
        if (chk_err)                        state_next = RESP;
        else if (cur_we && cur_size == 2'd3) state_next = WRITE;
        else                                state_next = READ;
      end
      READ: begin
        MemRead    = 1'b1;
        state_next = cur_we ? WRITE : RESP;
      end
      WRITE: begin
        MemWrite   = 1'b1;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner at grant, the check result in CHECK and the memory line in READ
  always_ff @(posedge clock) begin
    if (reset) begin
      cur_port  <= 1'b0;
      cur_we    <= 1'b0;
      cur_uns   <= 1'b0;
      cur_size  <= 2'd0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      cur_err   <= 1'b0;
      line      <= '0;
    end else begin
      case (state)
        IDLE: if (grant_valid) begin
          cur_port  <= grant_port;
          cur_we    <= grant_port ? p1_we       : p0_we;
          cur_uns   <= grant_port ? p1_unsigned : p0_unsigned;
          cur_size  <= grant_port ? p1_size     : p0_size;
          cur_addr  <= grant_port ? p1_addr     : p0_addr;
          cur_wdata <= grant_port ? p1_wdata    : p0_wdata;
          cur_err   <= 1'b0;
        end
        CHECK: cur_err <= chk_err;
        READ:  line    <= Read_Data;
        default: ;
      endcase
    end
  end

  // Byte-lane merge: lanes covered by the access take store data, the rest keep the line; sd covers all lanes
  always_comb begin
    logic [3:0] idx;
    logic [3:0] lane;
    merged = line;
    idx    = 4'd0;
    lane   = 4'd0;
    for (int i = 0; i < 8; i++) begin
      idx  = i[3:0];
      lane = idx - {1'b0, cur_addr[2:0]};
      if (idx >= {1'b0, cur_addr[2:0]} && idx < ({1'b0, cur_addr[2:0]} + nbytes))
        merged[i*8 +: 8] = cur_wdata[{lane[2:0], 3'b000} +: 8];
    end
  end

  // Load extraction: shift the addressed bytes down, then zero- or sign-extend from the access size
  always_comb begin
    shifted = line >> {cur_addr[2:0], 3'b000};
    case (cur_size)
      2'd0:    extended = cur_uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1:    extended = cur_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2:    extended = cur_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: extended = shifted;
    endcase
    load_data = (cur_we || cur_err) ? 64'd0 : extended;
  end

  // Memory-side address/data and per-port responses; all quiet outside their states
  always_comb begin
    Memory_Address = (state == IDLE) ? '0 : {cur_addr[ADDR_W-1:3], 3'b000};
    Write_Data     = (state == WRITE) ? merged : 64'd0;
    p0_done        = (state == RESP) && !cur_port;
    p1_done        = (state == RESP) &&  cur_port;
    p0_err         = p0_done && cur_err;
    p1_err         = p1_done && cur_err;
    p0_rdata       = p0_done ? load_data : 64'd0;
    p1_rdata       = p1_done ? load_data : 64'd0;
  end

endmodule
